// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch FSM for a 1-cycle-latency instruction memory with branch redirect and halt.
// Define IFU_INSTR_COUNT_EN to build the saturating advance/halt counter.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_now,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [3:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        misalign_err,
  output logic        halted,
  output logic [31:0] instr_count
);
  typedef enum logic [1:0] {S_REQ, S_CAPT, S_WAIT, S_HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic        valid_q, valid_d, mis_q, mis_d, adv, halt_go;
  assign halt_go = (state_q != S_HALT) && halt_now;
  assign adv     = (state_q == S_WAIT) && !pc_stall && !halt_now;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    if (halt_go) state_d = S_HALT;
    else case (state_q)
      S_REQ:  state_d = S_CAPT;
      S_CAPT: begin
        state_d = S_WAIT;
        instr_d = imem_rdata;
        valid_d = 1'b1;
      end
      S_WAIT: if (adv) begin
        state_d = S_REQ;
        valid_d = 1'b0;
        pc_d    = branch_taken ? {branch_target[31:2], 2'b00} : pc_q + 32'(PC_STEP);
        mis_d   = mis_q | (branch_taken && branch_target[1:0] != 2'b00);
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end
`ifdef IFU_INSTR_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = ((adv || halt_go) && ~&cnt_q) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif
  assign imem_en      = state_q == S_REQ;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign opcode       = instr_q[31:26];
  assign funct        = instr_q[3:0];
  assign instr_valid  = valid_q;
  assign misalign_err = mis_q;
  assign halted       = state_q == S_HALT;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random stimulus checked against a cycle-level behavioural model.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic        clk = 1'b0, rst = 1'b0, pc_stall = 1'b1, branch_taken = 1'b0, halt_now = 1'b0;
  logic [31:0] branch_target = '0, imem_rdata = '0;
  logic        imem_en, instr_valid, misalign_err, halted;
  logic [31:0] imem_addr, instr, pc, instr_count;
  logic [5:0]  opcode;
  logic [3:0]  funct;
  int          n_checks = 0, n_errors = 0;
  logic [31:0] pc_m, instr_m, cnt_m;
  logic        valid_m, mis_m, halt_m;
  int          busy_m;
  instr_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_now(halt_now), .imem_en(imem_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .funct(funct), .instr_valid(instr_valid), .pc(pc), .misalign_err(misalign_err),
    .halted(halted), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'd3 + 32'h0000_1234;
  endfunction
  always @(posedge clk) imem_rdata <= imem_en ? mem(imem_addr) : 32'hDEAD_BEEF;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // busy_m counts the cycles left before a requested fetch lands in instr.
  task automatic model(input logic r, s, b, input logic [31:0] t, input logic h);
    if (!r) begin
      pc_m = RESET_PC; instr_m = '0; valid_m = 0; mis_m = 0; halt_m = 0; cnt_m = '0; busy_m = 2;
    end else if (halt_m) begin
    end else if (h) begin
      halt_m = 1;
      if (cnt_m != 32'hFFFF_FFFF) cnt_m++;
    end else if (busy_m > 0) begin
      busy_m--;
      if (busy_m == 0) begin
        instr_m = mem(pc_m);
        valid_m = 1;
      end
    end else if (!s) begin
      if (b) begin
        pc_m = t & 32'hFFFF_FFFC;
        if (t[1:0] != 2'b00) mis_m = 1;
      end else pc_m = pc_m + 32'd4;
      valid_m = 0;
      busy_m = 2;
      if (cnt_m != 32'hFFFF_FFFF) cnt_m++;
    end
  endtask
  task automatic compare();
    chk("imem_en", 32'(imem_en), 32'(!halt_m && busy_m == 2));
    chk("imem_addr", imem_addr, pc_m);
    chk("pc", pc, pc_m);
    chk("instr", instr, instr_m);
    chk("opcode", 32'(opcode), 32'(instr_m[31:26]));
    chk("funct", 32'(funct), 32'(instr_m[3:0]));
    chk("instr_valid", 32'(instr_valid), 32'(valid_m));
    chk("misalign_err", 32'(misalign_err), 32'(mis_m));
    chk("halted", 32'(halted), 32'(halt_m));
`ifdef IFU_INSTR_COUNT_EN
    chk("instr_count", instr_count, cnt_m);
`else
    chk("instr_count", instr_count, 32'd0);
`endif
  endtask
  task automatic tick(input logic r, s, b, input logic [31:0] t, input logic h);
    rst = r; pc_stall = s; branch_taken = b; branch_target = t; halt_now = h;
    @(posedge clk);
    model(r, s, b, t, h);
    @(negedge clk);
    compare();
  endtask
  task automatic wait_ready();
    for (int i = 0; i < 8 && !(busy_m == 0 && !halt_m); i++) tick(1, 1, 0, '0, 0);
    if (!(busy_m == 0 && !halt_m)) chk("ready_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    tick(0, 1, 0, '0, 0);
    tick(0, 1, 0, '0, 0);
    chk("rst_en", 32'(imem_en), 32'd1);
    chk("rst_addr", imem_addr, 32'd0);
    tick(1, 1, 0, '0, 0);
    chk("c1_valid", 32'(instr_valid), 32'd0);
    tick(1, 1, 0, '0, 0);
    chk("c2_instr", instr, 32'h0000_1234);
    chk("c2_valid", 32'(instr_valid), 32'd1);
    repeat (3) tick(1, 1, 1, 32'h55, 0);
    chk("hold_instr", instr, 32'h0000_1234);
    for (int k = 1; k <= 3; k++) begin
      tick(1, 0, 0, '0, 0);
      chk("seq_addr", imem_addr, 32'(4 * k));
      chk("seq_en", 32'(imem_en), 32'd1);
      tick(1, 0, 1, 32'h80, 0);
      chk("lat_1", 32'(instr_valid), 32'd0);
      tick(1, 1, 0, '0, 0);
      chk("lat_2", 32'(instr_valid), 32'd1);
    end
    tick(1, 0, 1, 32'h0000_0102, 0);
    chk("br_addr", imem_addr, 32'h0000_0100);
    chk("br_mis", 32'(misalign_err), 32'd1);
    wait_ready();
    tick(1, 0, 1, 32'hFFFF_FFFC, 0);
    wait_ready();
    chk("mis_sticky", 32'(misalign_err), 32'd1);
    tick(1, 0, 0, '0, 0);
    chk("wrap_addr", imem_addr, 32'd0);
    wait_ready();
    tick(1, 0, 1, 32'h40, 1);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      chk("halt_en", 32'(imem_en), 32'd0);
    end
    tick(0, 1, 0, '0, 0);
    tick(1, 1, 0, '0, 0);
    wait_ready();
    tick(1, 0, 0, '0, 0);
    tick(1, 1, 0, '0, 0);
    tick(0, 1, 0, '0, 0);
    chk("capt_rst_instr", instr, 32'd0);
    chk("capt_rst_valid", 32'(instr_valid), 32'd0);
    chk("capt_rst_pc", pc, RESET_PC);
    chk("capt_rst_en", 32'(imem_en), 32'd1);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] t;
      t = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'h0000_FFFC);
      tick(1'($urandom_range(0, 79) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) == 0), t, 1'($urandom_range(0, 59) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
